// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU share arbiter.
package alu_share_arbiter_pkg;

    localparam int unsigned K       = 4;
    localparam int unsigned ALU_LAT = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StFlush = 2'd2
    } state_e;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

endpackage

// File: rtl/alu_share_arbiter_tag_delay_line.sv
// Result-owner tag shift register; the last stage lines up with the ALU result strobe.
module alu_share_arbiter_tag_delay_line
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_LAT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  tag_t i_tag,
    output tag_t o_tail,
    output logic o_any_v
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_comb begin
        o_any_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any_v = o_any_v | r_stage[i].v;
        end
    end

    assign o_tail = r_stage[DEPTH-1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin, job-granular arbiter sharing one ALU between two SMVM front-ends,
// with a latency-matched tag pipeline that routes each result back to its owner.
module alu_share_arbiter #(
    parameter int unsigned K       = alu_share_arbiter_pkg::K,
    parameter int unsigned ALU_LAT = alu_share_arbiter_pkg::ALU_LAT
) (
    input  logic [2*8*K-1:0] i_req_mat,
    input  logic [2*8*K-1:0] i_req_vec,
    input  logic [2*K-1:0]   i_req_ipv,
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    input  logic [1:0]       i_req_last,
    output logic [1:0]       o_req_ready,
    output logic [8*K-1:0]   o_alu_mat,
    output logic [8*K-1:0]   o_alu_vec,
    output logic [K-1:0]     o_alu_ipv,
    input  logic             i_alu_out_valid,
    input  logic [26*K-1:0]  i_alu_l4_out,
    input  logic [3:0]       i_alu_vov,
    output logic [1:0]       o_rsp_valid,
    output logic [26*K-1:0]  o_rsp_data,
    output logic [3:0]       o_rsp_vov,
    output logic             o_busy,
    output logic             o_err
);
    import alu_share_arbiter_pkg::*;

    state_e         r_state, w_state_nxt;
    logic           r_owner, w_owner_nxt;
    logic           r_last_served, w_last_served_nxt;
    logic           w_accept;
    logic [8*K-1:0] w_sel_mat, w_sel_vec;
    logic [K-1:0]   w_sel_ipv;
    logic [8*K-1:0] r_alu_mat, r_alu_vec;
    logic [K-1:0]   r_alu_ipv;
    logic           r_issue_v, r_issue_id;
    tag_t           w_tag_in, w_tail;
    logic           w_tags_any;
    logic           r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_served <= w_last_served_nxt;
        end
    end

    assign w_accept = (r_state == StBusy) && i_req_valid[r_owner];

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_served_nxt = r_last_served;
        unique case (r_state)
            StIdle: begin
                if (|i_req_valid) begin
                    w_state_nxt = StBusy;
                    // Tie goes to whoever was not served last.
                    w_owner_nxt = (&i_req_valid) ? ~r_last_served : i_req_valid[1];
                end
            end
            StBusy: begin
                if (w_accept && i_req_last[r_owner]) begin
                    w_state_nxt       = StFlush;
                    w_last_served_nxt = r_owner;
                end
            end
            StFlush: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (r_state == StBusy) begin
            o_req_ready[r_owner] = 1'b1;
        end
        o_busy = (r_state != StIdle) || r_issue_v || w_tags_any;
    end

    assign w_sel_mat = r_owner ? i_req_mat[16*K-1:8*K] : i_req_mat[8*K-1:0];
    assign w_sel_vec = r_owner ? i_req_vec[16*K-1:8*K] : i_req_vec[8*K-1:0];
    assign w_sel_ipv = r_owner ? i_req_ipv[2*K-1:K]    : i_req_ipv[K-1:0];

    // Non-accepted cycles drive an all-zero group, which the ALU treats as a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alu_mat  <= '0;
            r_alu_vec  <= '0;
            r_alu_ipv  <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= 1'b0;
        end else if (w_accept) begin
            r_alu_mat  <= w_sel_mat;
            r_alu_vec  <= w_sel_vec;
            r_alu_ipv  <= w_sel_ipv;
            r_issue_v  <= 1'b1;
            r_issue_id <= r_owner;
        end else begin
            r_alu_mat  <= '0;
            r_alu_vec  <= '0;
            r_alu_ipv  <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= 1'b0;
        end
    end

    assign o_alu_mat = r_alu_mat;
    assign o_alu_vec = r_alu_vec;
    assign o_alu_ipv = r_alu_ipv;

    assign w_tag_in = {r_issue_v, r_issue_id};

    alu_share_arbiter_tag_delay_line #(
        .DEPTH (ALU_LAT)
    ) u_tag_delay_line (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_tag   (w_tag_in),
        .o_tail  (w_tail),
        .o_any_v (w_tags_any)
    );

    // A tail tag without a result is a suppressed bubble and is dropped silently.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        o_rsp_vov   = '0;
        if (i_alu_out_valid && w_tail.v) begin
            o_rsp_valid[w_tail.id] = 1'b1;
            o_rsp_data             = i_alu_l4_out;
            o_rsp_vov              = i_alu_vov;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_alu_out_valid && !w_tail.v) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: an ALU model closes the loop and a scoreboard checks routing and timing.
module tb_alu_share_arbiter;

    localparam int TK   = 4;
    localparam int TLAT = 4;

    typedef struct {
        int                  due;
        logic [1:0]          valid;
        logic [26*TK-1:0]    data;
        logic [3:0]          vov;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_last = '0;
    logic [1:0]         req_ready;
    logic [2*8*TK-1:0]  req_mat = '0;
    logic [2*8*TK-1:0]  req_vec = '0;
    logic [2*TK-1:0]    req_ipv = '0;
    logic [8*TK-1:0]    alu_mat, alu_vec;
    logic [TK-1:0]      alu_ipv;
    logic               alu_out_valid;
    logic [26*TK-1:0]   alu_l4_out;
    logic [3:0]         alu_vov;
    logic [1:0]         rsp_valid;
    logic [26*TK-1:0]   rsp_data;
    logic [3:0]         rsp_vov;
    logic               busy, err;

    logic               inj_valid = 1'b0;
    logic [26*TK-1:0]   inj_data = '0;
    logic               mon_en = 1'b0;
    int                 cyc = 0;
    int                 errors = 0;
    int                 checks = 0;
    exp_t               q [$];

    logic [8*TK-1:0]    m_mat [TLAT];
    logic [8*TK-1:0]    m_vec [TLAT];
    logic [TK-1:0]      m_ipv [TLAT];
    logic               m_v   [TLAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_last      (req_last),
        .i_req_mat       (req_mat),
        .i_req_vec       (req_vec),
        .i_req_ipv       (req_ipv),
        .o_alu_mat       (alu_mat),
        .o_alu_vec       (alu_vec),
        .o_alu_ipv       (alu_ipv),
        .i_alu_out_valid (alu_out_valid),
        .i_alu_l4_out    (alu_l4_out),
        .i_alu_vov       (alu_vov),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_rsp_vov       (rsp_vov),
        .o_busy          (busy),
        .o_err           (err)
    );

    function automatic logic [26*TK-1:0] res_f(input logic [8*TK-1:0] m, input logic [8*TK-1:0] v,
                                               input logic [TK-1:0] p);
        return {4'hA, m ^ v, m, v, p};
    endfunction

    function automatic logic [3:0] vov_f(input logic [TK-1:0] p);
        return 4'(p[0]) + 4'(p[1]) + 4'(p[2]) + 4'(p[3]);
    endfunction

    // ALU model: fixed latency, suppresses all-zero bubble groups, shares rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLAT; i++) begin
                m_v[i] <= 1'b0; m_mat[i] <= '0; m_vec[i] <= '0; m_ipv[i] <= '0;
            end
        end else begin
            m_v[0]   <= (alu_ipv != '0) || (alu_mat != '0) || (alu_vec != '0);
            m_mat[0] <= alu_mat;
            m_vec[0] <= alu_vec;
            m_ipv[0] <= alu_ipv;
            for (int i = 1; i < TLAT; i++) begin
                m_v[i] <= m_v[i-1]; m_mat[i] <= m_mat[i-1];
                m_vec[i] <= m_vec[i-1]; m_ipv[i] <= m_ipv[i-1];
            end
        end
    end

    assign alu_out_valid = m_v[TLAT-1] | inj_valid;
    assign alu_l4_out    = inj_valid ? inj_data : res_f(m_mat[TLAT-1], m_vec[TLAT-1], m_ipv[TLAT-1]);
    assign alu_vov       = inj_valid ? 4'hF : vov_f(m_ipv[TLAT-1]);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: results must appear exactly on their due cycle and nowhere else.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rsp_valid", 128'(rsp_valid), 128'(e.valid));
                chk("rsp_data", 128'(rsp_data), 128'(e.data));
                chk("rsp_vov", 128'(rsp_vov), 128'(e.vov));
            end else begin
                chk("rsp_idle", 128'(rsp_valid), 128'(0));
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] last, input logic [1:0] exp_ready);
        logic [8*TK-1:0] mat [2];
        logic [8*TK-1:0] vec [2];
        logic [TK-1:0]   ipv [2];
        exp_t            e;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            mat[r] = $urandom;
            vec[r] = $urandom;
            ipv[r] = TK'($urandom_range(1, 15));
        end
        req_valid = v;
        req_last  = last;
        req_mat   = {mat[1], mat[0]};
        req_vec   = {vec[1], vec[0]};
        req_ipv   = {ipv[1], ipv[0]};
        @(negedge clk);
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        for (int r = 0; r < 2; r++) begin
            if (v[r] && exp_ready[r]) begin
                e.due      = cyc + TLAT + 1;
                e.valid    = '0;
                e.valid[r] = 1'b1;
                e.data     = res_f(mat[r], vec[r], ipv[r]);
                e.vov      = vov_f(ipv[r]);
                q.push_back(e);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_alu"}, 128'({alu_mat, alu_vec, alu_ipv}), 128'(0));
        chk({tag, "_rsp"}, 128'({rsp_valid, rsp_data, rsp_vov}), 128'(0));
        chk({tag, "_busy_err"}, 128'({busy, err}), 128'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        q.delete();
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 30) begin
            drive(2'b00, 2'b00, 2'b00);
            n++;
        end
        chk("drain_empty", 128'(q.size()), 128'(0));
        drive(2'b00, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00);
        chk("drain_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Single requester, 3-group job.
        drive(2'b01, 2'b00, 2'b00);
        drive(2'b01, 2'b00, 2'b01);
        drive(2'b01, 2'b00, 2'b01);
        drive(2'b01, 2'b01, 2'b01);
        chk("busy_job", 128'(busy), 128'(1));
        repeat (TLAT + 1) drive(2'b00, 2'b00, 2'b00);
        chk("busy_tail", 128'(busy), 128'(1));
        drive(2'b00, 2'b00, 2'b00);
        chk("busy_drop", 128'(busy), 128'(0));

        // Ties from reset: 0, then 1, then 0 again.
        do_reset();
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b01, 2'b01);
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b10, 2'b10);
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b01, 2'b01);
        drive(2'b00, 2'b00, 2'b00);
        drain();

        // Owner stalls while the other requester waits; then back-to-back job from 1.
        drive(2'b01, 2'b00, 2'b00);
        drive(2'b01, 2'b00, 2'b01);
        repeat (3) drive(2'b10, 2'b00, 2'b01);
        drive(2'b11, 2'b00, 2'b01);
        drive(2'b11, 2'b01, 2'b01);
        drive(2'b10, 2'b00, 2'b00);
        drive(2'b10, 2'b00, 2'b00);
        drive(2'b10, 2'b00, 2'b10);
        drive(2'b10, 2'b10, 2'b10);
        drive(2'b00, 2'b00, 2'b00);
        drain();

        // Orphan ALU result sets sticky err without a response.
        @(posedge clk); #1;
        inj_data  = {$urandom, $urandom, $urandom, $urandom};
        inj_valid = 1'b1;
        drive(2'b00, 2'b00, 2'b00);
        inj_valid = 1'b0;
        chk("err_set", 128'(err), 128'(1));
        repeat (3) drive(2'b00, 2'b00, 2'b00);
        chk("err_sticky", 128'(err), 128'(1));
        do_reset();
        chk("err_clear", 128'(err), 128'(0));

        // Reset mid-job with two tags in flight.
        drive(2'b01, 2'b00, 2'b00);
        drive(2'b01, 2'b00, 2'b01);
        drive(2'b01, 2'b00, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        chk("busy_inflight", 128'(busy), 128'(1));
        rst = 1'b1;
        q.delete();
        #1;
        chk_all_zero("midjob_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (TLAT + 4) drive(2'b00, 2'b00, 2'b00);
        chk("post_rst_err", 128'(err), 128'(0));
        drive(2'b11, 2'b00, 2'b00);
        drive(2'b11, 2'b01, 2'b01);
        drive(2'b00, 2'b00, 2'b00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
